// File: rtl/conv_pkg.sv
// conv_pkg: shared types and geometry for the 3x3 valid convolution scheduler.
// The image is 28x28 words starting at word 0, the nine weights sit at words
// 784..792 and the bias at word 793. Outputs form a 26x26 grid.
package conv_pkg;

   localparam int unsigned IMG_W  = 28;
   localparam int unsigned K      = 3;
   localparam int unsigned OUT_W  = 26;
   localparam int unsigned W_BASE = 784;
   localparam int unsigned B_WORD = 793;
   localparam int unsigned N_OUT  = 676;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD_W  = 3'd1,
      ST_LOAD_B  = 3'd2,
      ST_FETCH   = 3'd3,
      ST_COMPUTE = 3'd4,
      ST_WRITE   = 3'd5,
      ST_DONE    = 3'd6
   } state_t;

endpackage

// File: rtl/conv_win_addr.sv
// conv_win_addr: word address of tap k of the 3x3 window anchored at output
// (r,c). Tap k maps to (ky,kx) = (k/3, k%3); address = (r+ky)*IMG_W + (c+kx).
// Purely combinational; taps outside 0..8 resolve to the window origin.
module conv_win_addr
   import conv_pkg::*;
(
   input  logic [4:0]  i_r,
   input  logic [4:0]  i_c,
   input  logic [3:0]  i_k,
   output logic [31:0] o_word
);

   logic [1:0]  w_ky;
   logic [1:0]  w_kx;
   logic [31:0] w_row;
   logic [31:0] w_col;

   // Split the tap index into its row and column offsets inside the window.
   always_comb begin
      w_ky = 2'd0;
      w_kx = 2'd0;
      case (i_k)
         4'd0: begin w_ky = 2'd0; w_kx = 2'd0; end
         4'd1: begin w_ky = 2'd0; w_kx = 2'd1; end
         4'd2: begin w_ky = 2'd0; w_kx = 2'd2; end
         4'd3: begin w_ky = 2'd1; w_kx = 2'd0; end
         4'd4: begin w_ky = 2'd1; w_kx = 2'd1; end
         4'd5: begin w_ky = 2'd1; w_kx = 2'd2; end
         4'd6: begin w_ky = 2'd2; w_kx = 2'd0; end
         4'd7: begin w_ky = 2'd2; w_kx = 2'd1; end
         4'd8: begin w_ky = 2'd2; w_kx = 2'd2; end
         default: begin w_ky = 2'd0; w_kx = 2'd0; end
      endcase
   end

   assign w_row  = 32'(i_r) + 32'(w_ky);
   assign w_col  = 32'(i_c) + 32'(w_kx);
   assign o_word = w_row * IMG_W + w_col;

endmodule

// File: rtl/conv_sched.sv
// conv_sched: sequencer for one full 3x3 valid convolution of a 28x28 image.
// Loads nine weights and the bias once per start, then for each of the 676
// outputs fetches the nine window words, kicks the datapath, waits for it and
// writes the result. All M0 read strobes are decoded from the current state so
// that a returned word can be forwarded to the datapath in the following cycle.
// Optional build macro: CONV_SCHED_STATS_EN adds the cyc_cnt busy-cycle counter.
module conv_sched
   import conv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        finish,
   output logic        M0_R_req,
   output logic [31:0] M0_addr,
   input  logic [31:0] M0_R_data,
   output logic [3:0]  M1_W_req,
   output logic [31:0] M1_addr,
   output logic [31:0] M1_W_data,
   output logic        dp_w_load,
   output logic        dp_b_load,
   output logic        dp_in_load,
   output logic [3:0]  dp_idx,
   output logic [31:0] dp_data,
   output logic        dp_go,
   input  logic        dp_done,
   input  logic [31:0] dp_result
`ifdef CONV_SCHED_STATS_EN
   ,
   output logic [31:0] cyc_cnt
`endif
);

   localparam logic [3:0] TAP_LAST = 4'(K * K - 1);
   localparam logic [4:0] POS_LAST = 5'(OUT_W - 1);

   state_t      r_state;
   logic [4:0]  r_r;
   logic [4:0]  r_c;
   logic [3:0]  r_k;
   logic        r_finish;
   logic        r_wld;
   logic        r_bld;
   logic        r_inld;
   logic [3:0]  r_idx;
   logic        r_go;
   logic [3:0]  r_wreq;
   logic [31:0] r_m1_addr;
   logic [31:0] r_m1_data;

   logic [31:0] w_tap_word;
   logic [31:0] w_rd_word;
   logic        w_rd_req;
   logic [31:0] w_m1_word;
   logic        w_last_out;

   conv_win_addr u_win_addr (
      .i_r    (r_r),
      .i_c    (r_c),
      .i_k    (r_k),
      .o_word (w_tap_word)
   );

   assign w_m1_word  = 32'(r_r) * OUT_W + 32'(r_c);
   assign w_last_out = (r_r == POS_LAST) && (r_c == POS_LAST);

   // Decode the M0 read request and word address from the current state.
   always_comb begin
      w_rd_req  = 1'b0;
      w_rd_word = '0;
      case (r_state)
         ST_LOAD_W: begin
            w_rd_req  = 1'b1;
            w_rd_word = W_BASE + 32'(r_k);
         end
         ST_LOAD_B: begin
            w_rd_req  = 1'b1;
            w_rd_word = B_WORD;
         end
         ST_FETCH: begin
            if (r_k <= TAP_LAST) begin
               w_rd_req  = 1'b1;
               w_rd_word = w_tap_word;
            end
         end
         default: begin
            w_rd_req  = 1'b0;
            w_rd_word = '0;
         end
      endcase
   end

   // Sequencer: state, loop counters and the registered single-cycle strobes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_r       <= 5'd0;
         r_c       <= 5'd0;
         r_k       <= 4'd0;
         r_finish  <= 1'b0;
         r_wld     <= 1'b0;
         r_bld     <= 1'b0;
         r_inld    <= 1'b0;
         r_idx     <= 4'd0;
         r_go      <= 1'b0;
         r_wreq    <= 4'd0;
         r_m1_addr <= '0;
         r_m1_data <= '0;
      end else begin
         r_wld     <= 1'b0;
         r_bld     <= 1'b0;
         r_inld    <= 1'b0;
         r_idx     <= 4'd0;
         r_go      <= 1'b0;
         r_wreq    <= 4'd0;
         r_m1_addr <= '0;
         r_m1_data <= '0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_LOAD_W;
                  r_r     <= 5'd0;
                  r_c     <= 5'd0;
                  r_k     <= 4'd0;
               end
            end
            ST_LOAD_W: begin
               // Weight k requested now is presented next cycle.
               r_wld <= 1'b1;
               r_idx <= r_k;
               if (r_k == TAP_LAST) begin
                  r_k     <= 4'd0;
                  r_state <= ST_LOAD_B;
               end else begin
                  r_k <= r_k + 4'd1;
               end
            end
            ST_LOAD_B: begin
               r_bld   <= 1'b1;
               r_k     <= 4'd0;
               r_state <= ST_FETCH;
            end
            ST_FETCH: begin
               // k = 0..8 issue reads; k = 9 is the cycle tap 8 is presented,
               // so the kick lands in the following cycle.
               if (r_k <= TAP_LAST) begin
                  r_inld <= 1'b1;
                  r_idx  <= r_k;
                  r_k    <= r_k + 4'd1;
               end else begin
                  r_go    <= 1'b1;
                  r_k     <= 4'd0;
                  r_state <= ST_COMPUTE;
               end
            end
            ST_COMPUTE: begin
               // A done coinciding with the kick cycle cannot belong to it.
               if (dp_done && !r_go) begin
                  r_wreq    <= 4'b1111;
                  r_m1_addr <= {w_m1_word[29:0], 2'b00};
                  r_m1_data <= dp_result;
                  r_state   <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               r_k <= 4'd0;
               if (w_last_out) begin
                  r_r      <= 5'd0;
                  r_c      <= 5'd0;
                  r_finish <= 1'b1;
                  r_state  <= ST_DONE;
               end else begin
                  if (r_c == POS_LAST) begin
                     r_c <= 5'd0;
                     r_r <= r_r + 5'd1;
                  end else begin
                     r_c <= r_c + 5'd1;
                  end
                  r_state <= ST_FETCH;
               end
            end
            ST_DONE: begin
               if (start) begin
                  r_finish <= 1'b0;
                  r_r      <= 5'd0;
                  r_c      <= 5'd0;
                  r_k      <= 4'd0;
                  r_state  <= ST_LOAD_W;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef CONV_SCHED_STATS_EN
   logic [31:0] r_cyc;

   // Busy-cycle counter: restarts on an accepted start, holds in IDLE/DONE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cyc <= '0;
      end else if ((r_state == ST_IDLE || r_state == ST_DONE) && start) begin
         r_cyc <= '0;
      end else if (r_state != ST_IDLE && r_state != ST_DONE) begin
         r_cyc <= r_cyc + 32'd1;
      end
   end

   assign cyc_cnt = r_cyc;
`endif

   assign finish     = r_finish;
   assign M0_R_req   = w_rd_req;
   assign M0_addr    = {w_rd_word[29:0], 2'b00};
   assign M1_W_req   = r_wreq;
   assign M1_addr    = r_m1_addr;
   assign M1_W_data  = r_m1_data;
   assign dp_w_load  = r_wld;
   assign dp_b_load  = r_bld;
   assign dp_in_load = r_inld;
   assign dp_idx     = r_idx;
   assign dp_go      = r_go;
   // Memory data is forwarded only in a load cycle so the bus idles at zero.
   assign dp_data    = (r_wld || r_bld || r_inld) ? M0_R_data : '0;

endmodule
